wheel_encoder_reader: RTL

- Feedback-side counterpart to the motor PWM/DIR drive outputs: decodes the left and right wheel quadrature encoders (A/B per wheel).
- Maintains a signed position count per wheel.
- Measures signed speed as counts per fixed gate window.
- Flags illegal encoder transitions.
- Sits beside the motor drive logic under top and feeds closed-loop speed/turn control.

---
 rtl/wheel_encoder_reader_if.sv | 24 ++
 rtl/wheel_encoder_reader.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/wheel_encoder_reader_if.sv
// Encoder pins, clear request and decoded position/speed outputs
// for the left and right wheels.
interface wheel_encoder_reader_if #(
  parameter int POS_W = 16,
  parameter int SPD_W = 12
);
  logic                    ela, elb, era, erb;
  logic                    clr_pos;
  logic signed [POS_W-1:0] pos_l, pos_r;
  logic signed [SPD_W-1:0] spd_l, spd_r;
  logic                    spd_valid;
  logic                    dir_l, dir_r;
  logic                    err_l, err_r;

  modport master (
    output ela, elb, era, erb, clr_pos,
    input  pos_l, pos_r, spd_l, spd_r, spd_valid, dir_l, dir_r, err_l, err_r
  );

  modport slave (
    input  ela, elb, era, erb, clr_pos,
    output pos_l, pos_r, spd_l, spd_r, spd_valid, dir_l, dir_r, err_l, err_r
  );
endinterface

// File: rtl/wheel_encoder_reader.sv
// Dual-wheel quadrature decoder: synchronise and debounce A/B pins, track
// signed position and direction, and report signed counts per gate window.
module wheel_encoder_reader #(
  parameter int WINDOW_CYCLES = 1200000,
  parameter int FILT          = 3,
  parameter int POS_W         = 16,
  parameter int SPD_W         = 12
) (
  input logic                   sysclk,
  input logic                   rst,
  wheel_encoder_reader_if.slave enc
);
  localparam int FCW = $clog2(FILT + 1);
  localparam int WCW = $clog2(WINDOW_CYCLES);
  localparam logic signed [SPD_W-1:0] SPD_MAX = {1'b0, {(SPD_W-1){1'b1}}};
  localparam logic signed [SPD_W-1:0] SPD_MIN = {1'b1, {(SPD_W-1){1'b0}}};

  logic [3:0]              raw, sync1, sync2, filt;
  logic [FCW-1:0]          fcnt [4];
  logic [1:0]              cur [2];
  logic [1:0]              prev [2];
  logic                    primed [2];
  logic signed [1:0]       step [2];
  logic                    ill [2];
  logic signed [POS_W-1:0] pos [2];
  logic                    dir [2];
  logic                    err [2];
  logic [WCW-1:0]          wcnt;
  logic                    terminal;
  logic signed [SPD_W-1:0] acc [2];
  logic signed [SPD_W-1:0] acc_next [2];
  logic signed [SPD_W-1:0] spd [2];
  logic                    spd_valid_q;

  assign raw    = {enc.erb, enc.era, enc.elb, enc.ela};
  assign cur[0] = {filt[0], filt[1]};
  assign cur[1] = {filt[2], filt[3]};

  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    case (s)
      2'b00:   fwd_next = 2'b01;
      2'b01:   fwd_next = 2'b11;
      2'b11:   fwd_next = 2'b10;
      default: fwd_next = 2'b00;
    endcase
  endfunction

  // A filtered level flips only after FILT consecutive differing samples.
  always_ff @(posedge sysclk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      filt  <= '0;
      for (int i = 0; i < 4; i++) fcnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCW'(FILT - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FCW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      step[w] = 2'sd0;
      ill[w]  = 1'b0;
      if (primed[w] && (cur[w] != prev[w])) begin
        if (cur[w] == fwd_next(prev[w]))      step[w] = 2'sd1;
        else if (prev[w] == fwd_next(cur[w])) step[w] = -2'sd1;
        else                                  ill[w]  = 1'b1;
      end
    end
  end

  // The first filtered change after reset only seeds prev, so a wheel
  // parked at a nonzero state is never mistaken for a jump.
  always_ff @(posedge sysclk) begin
    if (!rst) begin
      for (int w = 0; w < 2; w++) begin
        prev[w]   <= 2'b00;
        primed[w] <= 1'b0;
        pos[w]    <= '0;
        dir[w]    <= 1'b0;
        err[w]    <= 1'b0;
      end
    end else begin
      for (int w = 0; w < 2; w++) begin
        prev[w] <= cur[w];
        if (cur[w] != prev[w]) primed[w] <= 1'b1;
        if (enc.clr_pos) begin
          pos[w] <= '0;
          err[w] <= 1'b0;
        end else begin
          pos[w] <= pos[w] + POS_W'(step[w]);
          err[w] <= err[w] | ill[w];
        end
        if (step[w] == 2'sd1)       dir[w] <= 1'b1;
        else if (step[w] == -2'sd1) dir[w] <= 1'b0;
      end
    end
  end

  assign terminal = (wcnt == WCW'(WINDOW_CYCLES - 1));

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      acc_next[w] = acc[w];
      if ((step[w] == 2'sd1) && (acc[w] != SPD_MAX))       acc_next[w] = acc[w] + SPD_W'(1);
      else if ((step[w] == -2'sd1) && (acc[w] != SPD_MIN)) acc_next[w] = acc[w] - SPD_W'(1);
    end
  end

  // The terminal cycle's own step is folded into the reported window.
  always_ff @(posedge sysclk) begin
    if (!rst) begin
      wcnt        <= '0;
      spd_valid_q <= 1'b0;
      for (int w = 0; w < 2; w++) begin
        acc[w] <= '0;
        spd[w] <= '0;
      end
    end else begin
      spd_valid_q <= terminal;
      wcnt        <= terminal ? '0 : wcnt + WCW'(1);
      for (int w = 0; w < 2; w++) begin
        if (terminal) begin
          spd[w] <= acc_next[w];
          acc[w] <= '0;
        end else begin
          acc[w] <= acc_next[w];
        end
      end
    end
  end

  assign enc.pos_l     = pos[0];
  assign enc.pos_r     = pos[1];
  assign enc.dir_l     = dir[0];
  assign enc.dir_r     = dir[1];
  assign enc.err_l     = err[0];
  assign enc.err_r     = err[1];
  assign enc.spd_l     = spd[0];
  assign enc.spd_r     = spd[1];
  assign enc.spd_valid = spd_valid_q;
endmodule
